// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the KGP_RISC datapath.
// It holds the architectural PC and feeds it, with a constant step, into the
// shared 32-bit adder. The adder's sum comes back as the sequential next PC.
// It then picks between the sequential, branch and jump targets, and handles
// the start, stall and halt controls.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target halts the core and raises a sticky misalign_err.
// When it is undefined, target bits [1:0] are cleared on load.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_STEP        = 32'd4,
    parameter int          IMEM_ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    input  logic                      jump,
    input  logic [31:0]               jump_target,
    input  logic                      halt,
    output logic [31:0]               add_in_a,
    output logic [31:0]               add_in_b,
    input  logic [31:0]               add_result,
    output logic [31:0]               pc,
    output logic [IMEM_ADDR_BITS-1:0] imem_addr,
    output logic                      pc_valid,
    output logic                      halted,
    output logic [31:0]               retired_count
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic                      misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] retired_q;
    logic        pc_valid_q;
    logic        halted_q;

    logic        redirect_d;
    logic [31:0] target_raw_d;
    logic [31:0] target_d;

`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic        misaligned_d;
`else
    logic        unused_target_lsbs;
`endif

    // Redirect target selection: a jump outranks a taken branch.
    always_comb begin
        redirect_d   = jump | branch_taken;
        target_raw_d = jump ? jump_target : branch_target;
`ifdef PC_MISALIGN_TRAP_EN
        target_d     = target_raw_d;
        misaligned_d = redirect_d && (target_raw_d[1:0] != 2'b00);
`else
        target_d           = {target_raw_d[31:2], 2'b00};
        unused_target_lsbs = ^target_raw_d[1:0];
`endif
    end

    // Sequencer FSM. It owns the PC, the retire counter and the status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            retired_q  <= 32'd0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // The PC is left unchanged, so the first fetch is RESET_PC.
                    if (start) begin
                        state_q    <= RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        // The PC of the halt cycle is kept for debug.
                        state_q    <= HALTED;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (redirect_d) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (misaligned_d) begin
                            state_q    <= HALTED;
                            pc_q       <= target_d;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= target_d;
                            if (!stall) begin
                                retired_q <= retired_q + 32'd1;
                            end
                        end
`else
                        pc_q <= target_d;
                        if (!stall) begin
                            retired_q <= retired_q + 32'd1;
                        end
`endif
                    end else if (!stall) begin
                        pc_q      <= add_result;
                        retired_q <= retired_q + 32'd1;
                    end
                end
                HALTED: begin
                    // Only reset leaves this state.
                    state_q <= HALTED;
                end
                default: begin
                    state_q    <= IDLE;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    // The adder operands and the fetch address are taken directly from the PC register.
    always_comb begin
        add_in_a      = pc_q;
        add_in_b      = PC_STEP;
        pc            = pc_q;
        imem_addr     = pc_q[IMEM_ADDR_BITS+1:2];
        pc_valid      = pc_valid_q;
        halted        = halted_q;
        retired_count = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_err  = misalign_q;
`endif
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. It applies a table of single-cycle vectors with
// hand-computed expected state, then runs a few hand-written multi-cycle
// sequences. The external 32-bit adder is modelled here as a plain sum.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] add_in_a;
    logic [31:0] add_in_b;
    logic [31:0] add_result;
    logic [31:0] pc;
    logic [9:0]  imem_addr;
    logic        pc_valid;
    logic        halted;
    logic [31:0] retired_count;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int total;
    int bad;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        halt;
        logic [31:0] ePc;
        logic        eValid;
        logic        eHalted;
        logic [31:0] eRet;
        logic        eMis;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP(32'd4),
        .IMEM_ADDR_BITS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .halt(halt),
        .add_in_a(add_in_a),
        .add_in_b(add_in_b),
        .add_result(add_result),
        .pc(pc),
        .imem_addr(imem_addr),
        .pc_valid(pc_valid),
        .halted(halted),
        .retired_count(retired_count)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    // This models the external datapath adder.
    assign add_result = add_in_a + add_in_b;

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic r, input logic s, input logic st,
                          input logic b, input logic [31:0] bt,
                          input logic jj, input logic [31:0] jt,
                          input logic h, input logic [31:0] ePc,
                          input logic eV, input logic eH,
                          input logic [31:0] eR, input logic eM);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.br = b; v.brt = bt;
        v.j = jj; v.jt = jt; v.halt = h; v.ePc = ePc; v.eValid = eV;
        v.eHalted = eH; v.eRet = eR; v.eMis = eM;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs at the falling edge and waits past the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        start         = v.start;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.brt;
        jump          = v.j;
        jump_target   = v.jt;
        halt          = v.halt;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] ePc, input logic eV,
                               input logic eH, input logic [31:0] eR, input logic eM);
        logic [31:0] expImem;
        expImem = (ePc >> 2) & 32'h3FF;
        cmp({tag, " pc"}, pc, ePc);
        cmp({tag, " add_in_a"}, add_in_a, ePc);
        cmp({tag, " add_in_b"}, add_in_b, 32'd4);
        cmp({tag, " imem_addr"}, {22'd0, imem_addr}, expImem);
        cmp({tag, " pc_valid"}, {31'd0, pc_valid}, {31'd0, eV});
        cmp({tag, " halted"}, {31'd0, halted}, {31'd0, eH});
        cmp({tag, " retired"}, retired_count, eR);
`ifdef PC_MISALIGN_TRAP_EN
        cmp({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, eM});
`else
        if (eM) begin
            $display("[TB] note: vector %s expects a trap, but this build has none", tag);
        end
`endif
    endtask

    initial begin
        vec_t idleV;
        logic [31:0] mPc;
        logic [31:0] mRet;
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0; halt = 1'b0;

        //     rst start stall br brt          j  jt            halt ePc           V  H  ret    mis
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 32'd0, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 32'd0, 0);
        addVec(0, 0, 1, 0, 32'h0,        1, 32'h80,       0, 32'h0000_0000, 0, 0, 32'd0, 0);
        addVec(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'd0, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 1, 0, 32'd1, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'd2, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_000C, 1, 0, 32'd3, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'd4, 0);
        addVec(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'd4, 0);
        addVec(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'd4, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0014, 1, 0, 32'd5, 0);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'h20,       0, 32'h0000_0020, 1, 0, 32'd6, 0);
        addVec(0, 0, 1, 1, 32'h200,      1, 32'h100,      0, 32'h0000_0100, 1, 0, 32'd6, 0);
        addVec(0, 0, 0, 1, 32'h40,       0, 32'h0,        0, 32'h0000_0040, 1, 0, 32'd7, 0);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'h300,      1, 32'h0000_0040, 0, 1, 32'd7, 0);
        addVec(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0040, 0, 1, 32'd7, 0);
        addVec(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 32'd0, 0);
        addVec(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'd0, 0);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 32'd1, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'd2, 0);
`ifdef PC_MISALIGN_TRAP_EN
        addVec(0, 0, 0, 1, 32'h102,      0, 32'h0,        0, 32'h0000_0102, 0, 1, 32'd2, 1);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0102, 0, 1, 32'd2, 1);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'h203,      0, 32'h0000_0102, 0, 1, 32'd2, 1);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0102, 0, 1, 32'd2, 1);
`else
        addVec(0, 0, 0, 1, 32'h102,      0, 32'h0,        0, 32'h0000_0100, 1, 0, 32'd3, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0104, 1, 0, 32'd4, 0);
        addVec(0, 0, 0, 0, 32'h0,        1, 32'h203,      0, 32'h0000_0200, 1, 0, 32'd5, 0);
        addVec(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0200, 0, 1, 32'd5, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eValid,
                        vecs[i].eHalted, vecs[i].eRet, vecs[i].eMis);
        end

        // Hand sequence: reset, start, then alternate stall over several cycles.
        idleV = '{rst: 1'b1, start: 1'b0, stall: 1'b0, br: 1'b0, brt: 32'd0,
                  j: 1'b0, jt: 32'd0, halt: 1'b0, ePc: 32'd0, eValid: 1'b0,
                  eHalted: 1'b0, eRet: 32'd0, eMis: 1'b0};
        applyStimulus(idleV);
        checkOutput("seq reset", 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        idleV.rst   = 1'b0;
        idleV.start = 1'b1;
        applyStimulus(idleV);
        checkOutput("seq start", 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        idleV.start = 1'b0;
        mPc  = 32'd0;
        mRet = 32'd0;
        for (int i = 0; i < 6; i++) begin
            idleV.stall = (i % 2) == 1;
            applyStimulus(idleV);
            if (!idleV.stall) begin
                mPc  = mPc + 32'd4;
                mRet = mRet + 32'd1;
            end
            checkOutput($sformatf("seq stall%0d", i), mPc, 1'b1, 1'b0, mRet, 1'b0);
        end

        // Hand sequence: a reset in the middle of RUN returns to IDLE at RESET_PC.
        idleV.stall = 1'b0;
        idleV.rst   = 1'b1;
        applyStimulus(idleV);
        checkOutput("seq midrst", 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        idleV.rst = 1'b0;
        applyStimulus(idleV);
        checkOutput("seq idlehold", 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
